regfile_wb_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order pipeline writeback stage and the multi-cycle mul/div unit. Requesters use valid/ready handshakes, and the winning write passes through one registered output stage that drives the register file's write address, write enable and write data. The block also holds a per-register pending scoreboard for mul/div destinations, so decode can stall on RAW hazards.

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Register address/word types and the grant source enum.
package regfile_wb_arbiter_pkg;

    localparam int unsigned NREGS = 32;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_MD   = 1'b1
    } wb_src_e;

    function automatic logic is_x0(input creg_addr_t a);
        return a == '0;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for mul/div destinations.
// Drives issue_ready and the decode RAW stall.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       issue_valid_i,
    input  creg_addr_t issue_addr_i,
    output logic       issue_ready_o,
    input  logic       clr_i,
    input  creg_addr_t clr_addr_i,
    input  creg_addr_t ra1_i,
    input  creg_addr_t ra2_i,
    output logic       stall_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             set;

    assign issue_ready_o = resetn &&
        (is_x0(issue_addr_i) || !pending_q[issue_addr_i]);

    assign set = issue_valid_i && issue_ready_o &&
        !is_x0(issue_addr_i);

    assign stall_o =
        (!is_x0(ra1_i) && pending_q[ra1_i]) ||
        (!is_x0(ra2_i) && pending_q[ra2_i]);

    // Set is applied after clear so a same-cycle reissue stays pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set) begin
            pending_d[issue_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs mul/div.
// Optional same-cycle bypass outputs under REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  creg_addr_t wb_addr,
    input  word_t      wb_data,
    input  logic       md_valid,
    output logic       md_ready,
    input  creg_addr_t md_addr,
    input  word_t      md_data,
    input  logic       md_issue_valid,
    output logic       md_issue_ready,
    input  creg_addr_t md_issue_addr,
    input  creg_addr_t ra1,
    input  creg_addr_t ra2,
    output logic       stall,
    output creg_addr_t wa3,
    output word_t      wd3,
    output logic       we3
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic       fwd1_hit,
    output logic       fwd2_hit,
    output word_t      fwd_data
`endif
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_WAIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       starved;
    logic       wb_go;
    logic       md_go;
    wb_src_e    src;
    creg_addr_t sel_addr;
    word_t      sel_data;

    creg_addr_t wa3_q;
    creg_addr_t wa3_d;
    word_t      wd3_q;
    word_t      wd3_d;
    logic       we3_q;
    logic       we3_d;

    assign starved  = cnt_q == CNT_MAX;
    assign wb_ready = resetn && !(md_valid && starved);
    assign md_ready = resetn && (!wb_valid || starved);
    assign wb_go    = wb_valid && wb_ready;
    assign md_go    = md_valid && md_ready;
    assign src      = md_go ? WB_SRC_MD : WB_SRC_PIPE;

    always_comb begin
        sel_addr = wb_addr;
        sel_data = wb_data;
        unique case (src)
            WB_SRC_MD: begin
                sel_addr = md_addr;
                sel_data = md_data;
            end
            WB_SRC_PIPE: begin
                sel_addr = wb_addr;
                sel_data = wb_data;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (md_go) begin
            cnt_d = '0;
        end else if (md_valid && !md_ready && !starved) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (wb_go || md_go) begin
            wa3_d = sel_addr;
            wd3_d = sel_data;
            we3_d = !is_x0(sel_addr);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            we3_q <= we3_d;
            wa3_q <= wa3_d;
            wd3_q <= wd3_d;
        end
    end

    assign wa3 = wa3_q;
    assign wd3 = wd3_q;
    assign we3 = we3_q;

    regfile_scoreboard u_sb (
        .clk           (clk),
        .resetn        (resetn),
        .issue_valid_i (md_issue_valid),
        .issue_addr_i  (md_issue_addr),
        .issue_ready_o (md_issue_ready),
        .clr_i         (md_go),
        .clr_addr_i    (md_addr),
        .ra1_i         (ra1),
        .ra2_i         (ra2),
        .stall_o       (stall)
    );

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd1_hit = we3_q && (wa3_q == ra1) && !is_x0(ra1);
    assign fwd2_hit = we3_q && (wa3_q == ra2) && !is_x0(ra2);
    assign fwd_data = wd3_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps plus
// randomized traffic against a spec-level reference model.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_addr = '0;
    logic [31:0] md_data = '0;
    logic        md_issue_valid = 1'b0;
    logic        md_issue_ready;
    logic [4:0]  md_issue_addr = '0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic        stall;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        we3;
`ifdef REGFILE_WB_BYPASS_EN
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
`endif

    int n_asserts = 0;
    int n_fail = 0;

    // Reference model state
    int          m_cnt;
    bit          m_pend[32];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          last_wb_x;
    bit          last_md_x;

    logic [31:0] rf[32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn && we3) rf[wa3] <= wd3;
    end

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .md_valid       (md_valid),
        .md_ready       (md_ready),
        .md_addr        (md_addr),
        .md_data        (md_data),
        .md_issue_valid (md_issue_valid),
        .md_issue_ready (md_issue_ready),
        .md_issue_addr  (md_issue_addr),
        .ra1            (ra1),
        .ra2            (ra2),
        .stall          (stall),
        .wa3            (wa3),
        .wd3            (wd3),
        .we3            (we3)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .fwd1_hit       (fwd1_hit),
        .fwd2_hit       (fwd2_hit),
        .fwd_data       (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_we = 0;
        m_wa = '0;
        m_wd = '0;
        last_wb_x = 0;
        last_md_x = 0;
        for (int k = 0; k < 32; k++) m_pend[k] = 0;
    endtask

    // Check the current cycle against the model, then advance one edge.
    task automatic tick();
        bit e_wr, e_mr, e_ir, e_st;
        bit wx, mx, ix;
        int n_cnt;
        #1;
        e_wr = !(md_valid && m_cnt == MAX_WAIT);
        e_mr = !wb_valid || m_cnt == MAX_WAIT;
        e_ir = (md_issue_addr == 0) || !m_pend[md_issue_addr];
        e_st = (ra1 != 0 && m_pend[ra1]) || (ra2 != 0 && m_pend[ra2]);
        chk("wb_ready", 32'(wb_ready), 32'(e_wr));
        chk("md_ready", 32'(md_ready), 32'(e_mr));
        chk("issue_ready", 32'(md_issue_ready), 32'(e_ir));
        chk("stall", 32'(stall), 32'(e_st));
        chk("we3", 32'(we3), 32'(m_we));
        chk("wa3", 32'(wa3), 32'(m_wa));
        chk("wd3", wd3, m_wd);
`ifdef REGFILE_WB_BYPASS_EN
        chk("fwd1_hit", 32'(fwd1_hit), 32'(m_we && m_wa == ra1 && ra1 != 0));
        chk("fwd2_hit", 32'(fwd2_hit), 32'(m_we && m_wa == ra2 && ra2 != 0));
        chk("fwd_data", fwd_data, m_wd);
`endif
        wx = wb_valid && e_wr;
        mx = md_valid && e_mr;
        ix = md_issue_valid && e_ir;
        n_cnt = m_cnt;
        if (mx) n_cnt = 0;
        else if (md_valid && !e_mr && m_cnt < MAX_WAIT) n_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
        last_wb_x = wx;
        last_md_x = mx;
        m_cnt = n_cnt;
        m_we = 0;
        if (wx) begin
            m_wa = wb_addr; m_wd = wb_data; m_we = (wb_addr != 0);
        end
        if (mx) begin
            m_wa = md_addr; m_wd = md_data; m_we = (md_addr != 0);
            m_pend[md_addr] = 0;
        end
        if (ix && md_issue_addr != 0) m_pend[md_issue_addr] = 1;
    endtask

    task automatic idle();
        wb_valid = 0;
        md_valid = 0;
        md_issue_valid = 0;
        ra1 = '0;
        ra2 = '0;
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 32; k++) rf[k] = '0;

        // Reset state
        #2;
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);
        chk("rst_md_ready", 32'(md_ready), 32'd0);
        chk("rst_issue_ready", 32'(md_issue_ready), 32'd0);
        chk("rst_we3", 32'(we3), 32'd0);
        chk("rst_wa3", 32'(wa3), 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        // wb only: r5 = 0x1234, readback two cycles later
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        idle();
        #1;
        chk("wb_we3", 32'(we3), 32'd1);
        chk("wb_wa3", 32'(wa3), 32'd5);
        chk("wb_wd3", wd3, 32'h1234);
        tick();
        chk("readback_r5", rf[5], 32'h1234);

        // Starvation: md waits MAX_WAIT cycles then wins
        wb_valid = 1; wb_addr = 5'd11; wb_data = 32'h1111_0000;
        md_valid = 1; md_addr = 5'd10; md_data = 32'h2222_0000;
        for (int i = 0; i <= MAX_WAIT; i++) begin
            #1;
            chk("starve_md_ready", 32'(md_ready), 32'(i == MAX_WAIT));
            tick();
        end
        chk("starve_md_granted", 32'(last_md_x), 32'd1);
        #1;
        chk("starve_cnt_clr", 32'(md_ready), 32'd0);
        chk("starve_wd3", wd3, 32'h2222_0000);
        tick();
        idle();
        tick();

        // Issue to r7, refused reissue, md write clears
        md_issue_valid = 1; md_issue_addr = 5'd7;
        tick();
        ra1 = 5'd7;
        #1;
        chk("iss_stall", 32'(stall), 32'd1);
        chk("iss_refused", 32'(md_issue_ready), 32'd0);
        tick();
        md_issue_valid = 0;
        md_valid = 1; md_addr = 5'd7; md_data = 32'h7777;
        tick();
        md_valid = 0;
        #1;
        chk("iss_cleared", 32'(stall), 32'd0);
        tick();

        // Same-cycle md write and issue to r9: set wins
        md_valid = 1; md_addr = 5'd9; md_data = 32'h9999;
        md_issue_valid = 1; md_issue_addr = 5'd9;
        tick();
        idle();
        ra2 = 5'd9;
        #1;
        chk("setwin_stall", 32'(stall), 32'd1);
        tick();
        md_valid = 1; md_addr = 5'd9;
        tick();
        idle();

        // Writes to r0 complete but do not enable
        wb_valid = 1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        tick();
        chk("r0_wb_xfer", 32'(last_wb_x), 32'd1);
        wb_valid = 0;
        md_valid = 1; md_addr = 5'd0; md_data = 32'hBEEF;
        #1;
        chk("r0_wb_we3", 32'(we3), 32'd0);
        tick();
        chk("r0_md_xfer", 32'(last_md_x), 32'd1);
        idle();
        #1;
        chk("r0_md_we3", 32'(we3), 32'd0);
        tick();

`ifdef REGFILE_WB_BYPASS_EN
        wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hABCD;
        tick();
        idle();
        ra2 = 5'd3;
        #1;
        chk("byp_fwd2_hit", 32'(fwd2_hit), 32'd1);
        chk("byp_fwd_data", fwd_data, 32'hABCD);
        tick();
        idle();
`endif

        // Randomized traffic, requesters hold until accepted
        for (int i = 0; i < 400; i++) begin
            if (!(wb_valid && !last_wb_x)) begin
                wb_valid = 1'($urandom_range(0, 1));
                wb_addr = 5'($urandom_range(0, 7));
                wb_data = $urandom;
            end
            if (!(md_valid && !last_md_x)) begin
                md_valid = 1'($urandom_range(0, 1));
                md_addr = 5'($urandom_range(0, 7));
                md_data = $urandom;
            end
            md_issue_valid = 1'($urandom_range(0, 1));
            md_issue_addr = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            ra2 = 5'($urandom_range(0, 7));
            tick();
        end
        idle();
        tick();

        // Asynchronous reset mid-stream
        md_issue_valid = 1; md_issue_addr = 5'd12;
        wb_valid = 1; wb_addr = 5'd4; wb_data = 32'h4444;
        tick();
        idle();
        ra1 = 5'd12;
        #1;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        chk("pre_rst_we3", 32'(we3), 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_we3", 32'(we3), 32'd0);
        chk("arst_wa3", 32'(wa3), 32'd0);
        chk("arst_wd3", wd3, 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_issue_ready", 32'(md_issue_ready), 32'd0);
        chk("arst_wb_ready", 32'(wb_ready), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (!(wb_valid && !last_wb_x)) begin
                wb_valid = 1'($urandom_range(0, 1));
                wb_addr = 5'($urandom);
                wb_data = $urandom;
            end
            if (!(md_valid && !last_md_x)) begin
                md_valid = 1'($urandom_range(0, 1));
                md_addr = 5'($urandom);
                md_data = $urandom;
            end
            md_issue_valid = 1'($urandom_range(0, 1));
            md_issue_addr = 5'($urandom);
            ra1 = 5'($urandom);
            ra2 = md_issue_addr;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
